// File: rtl/serial_add_seq_pkg.sv
// Shared constants for the bit-serial add/subtract controller:
// FSM state encodings and the add/subtract opcode values.
package serial_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_seq_if.sv
// Request/result bundle of serial_add_seq: the requester drives operands and
// start, the sequencer returns busy/done and the registered results.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    modport master (
        output start, Sub, A, B, Cin,
        input  busy, done, Sum, Cout, Overflow
    );

    modport slave (
        input  start, Sub, A, B, Cin,
        output busy, done, Sum, Cout, Overflow
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder: the single arithmetic slice reused for every bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract: one full_adder walks the operands LSB first, one
// bit per clock, with the carry held in a flop between bits.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic           clk,
    input logic           rst,
    serial_add_seq_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             c_msb_in_q, c_msb_in_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s, fa_cout;

    full_adder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        res_d      = res_q;
        carry_d    = carry_q;
        c_msb_in_d = c_msb_in_q;
        done_d     = 1'b0;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.A;
                    sb_d    = (bus.Sub == OP_SUB) ? ~bus.B : bus.B;
                    carry_d = (bus.Sub == OP_SUB) ? 1'b1 : bus.Cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    c_msb_in_d = carry_q;
                    state_d    = ST_FIN;
                end
            end
            ST_FIN: begin
                sum_d   = res_q;
                cout_d  = carry_q;
                ovf_d   = c_msb_in_q ^ carry_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every register, operand shifters included.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sa_q       <= '0;
            sb_q       <= '0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            c_msb_in_q <= c_msb_in_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.Sum      = sum_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and model-checked bench for serial_add_seq at WIDTH=8 and WIDTH=5.
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_add_seq_if #(.WIDTH(8)) bus8 ();
    serial_add_seq_if #(.WIDTH(5)) bus5 ();

    serial_add_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_seq #(.WIDTH(5)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: sign-rule overflow, carry from the widened sum.
    task automatic model(input int w, input bit sub, input int a, input int b, input bit cin,
                         output int sum, output bit cout, output bit ovf);
        int mask, bb, full;
        mask = (1 << w) - 1;
        bb   = sub ? (~b & mask) : (b & mask);
        full = (a & mask) + bb + (sub ? 1 : int'(cin));
        sum  = full & mask;
        cout = full[w];
        ovf  = (a[w-1] == bb[w-1]) && (sum[w-1] != a[w-1]);
    endtask

    task automatic drive8(input bit sub, input logic [7:0] a, input logic [7:0] b, input bit cin);
        bus8.Sub = sub;
        bus8.A   = a;
        bus8.B   = b;
        bus8.Cin = cin;
    endtask

    // Start one 8-bit operation and check latency and results.
    task automatic op8(input string tag, input bit sub, input logic [7:0] a, input logic [7:0] b,
                       input bit cin, input logic [7:0] es, input bit ec, input bit eo);
        int lat;
        drive8(sub, a, b, cin);
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (bus8.done) lat = k;
        end
        check({tag, "_lat"}, lat, 9);
        check({tag, "_sum"}, bus8.Sum, es);
        check({tag, "_cout"}, bus8.Cout, ec);
        check({tag, "_ovf"}, bus8.Overflow, eo);
    endtask

    initial begin
        bit   seen_done;
        int   lat8, lat5, es8, es5;
        bit   ec8, ec5, eo8, eo5, sub;
        int   a8, b8, a5, b5;
        bit   cin;

        bus8.start = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        bus5.start = 1'b0;
        bus5.Sub = 1'b0; bus5.A = '0; bus5.B = '0; bus5.Cin = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", bus8.busy, 0);
        check("rst_done", bus8.done, 0);
        check("rst_sum", bus8.Sum, 8'h00);
        check("rst_cout_ovf", {bus8.Cout, bus8.Overflow}, 2'b00);

        // First request with explicit busy/done timing.
        drive8(1'b0, 8'h0F, 8'h01, 1'b0);
        bus8.start = 1'b1;
        tick();                                   // edge T
        bus8.start = 1'b0;
        tick();                                   // T+1
        check("t1_busy_T1", bus8.busy, 1);
        for (int k = 2; k <= 8; k++) tick();      // T+8
        check("t1_busy_T8", bus8.busy, 1);
        check("t1_done_T8", bus8.done, 0);
        tick();                                   // T+9
        check("t1_done_T9", bus8.done, 1);
        check("t1_busy_T9", bus8.busy, 0);
        check("t1_sum", bus8.Sum, 8'h10);
        check("t1_cout_ovf", {bus8.Cout, bus8.Overflow}, 2'b00);
        tick();
        check("t1_done_pulse", bus8.done, 0);

        op8("add_wrap", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_ovf",  1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        op8("sub_brw",  1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        op8("sub_ovf",  1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start during a run is ignored; start held in the done cycle is accepted.
        drive8(1'b0, 8'h10, 8'h20, 1'b0);
        bus8.start = 1'b1;
        tick();                                   // T
        bus8.start = 1'b0;
        tick(); tick();                           // T+2
        drive8(1'b1, 8'hAA, 8'h55, 1'b1);
        bus8.start = 1'b1;
        tick();                                   // T+3
        bus8.start = 1'b0;
        tick(); tick();                           // T+5
        check("ign_sum_hold", bus8.Sum, 8'h7F);
        for (int k = 6; k <= 9; k++) tick();      // T+9
        check("ign_done", bus8.done, 1);
        check("ign_sum", bus8.Sum, 8'h30);
        drive8(1'b0, 8'h33, 8'h44, 1'b0);
        bus8.start = 1'b1;
        tick();                                   // T+10
        bus8.start = 1'b0;
        check("b2b_busy", bus8.busy, 1);
        for (int k = 11; k <= 18; k++) tick();    // T+18
        check("b2b_done_T18", bus8.done, 0);
        tick();                                   // T+19
        check("b2b_done_T19", bus8.done, 1);
        check("b2b_sum", bus8.Sum, 8'h77);

        // Reset in the middle of a run.
        tick();
        drive8(1'b0, 8'h12, 8'h34, 1'b0);
        bus8.start = 1'b1;
        tick();                                   // T
        bus8.start = 1'b0;
        tick(); tick(); tick();                   // T+3
        rst = 1'b1;
        tick();                                   // T+4
        rst = 1'b0;
        tick();                                   // T+5
        check("mid_rst_busy", bus8.busy, 0);
        check("mid_rst_done", bus8.done, 0);
        check("mid_rst_sum", bus8.Sum, 8'h00);
        check("mid_rst_cout_ovf", {bus8.Cout, bus8.Overflow}, 2'b00);
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus8.done) seen_done = 1'b1;
        end
        check("mid_rst_no_done", seen_done, 0);
        op8("post_rst", 1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // 100 paired operations: 100 at WIDTH=8 and 100 at WIDTH=5.
        for (int n = 0; n < 100; n++) begin
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255);
            a5 = $urandom_range(0, 31);  b5 = $urandom_range(0, 31);
            model(8, sub, a8, b8, cin, es8, ec8, eo8);
            model(5, sub, a5, b5, cin, es5, ec5, eo5);
            drive8(sub, 8'(a8), 8'(b8), cin);
            bus5.Sub = sub; bus5.A = 5'(a5); bus5.B = 5'(b5); bus5.Cin = cin;
            bus8.start = 1'b1;
            bus5.start = 1'b1;
            tick();
            bus8.start = 1'b0;
            bus5.start = 1'b0;
            lat8 = -1;
            lat5 = -1;
            for (int k = 1; k <= 12; k++) begin
                tick();
                if (bus8.done && lat8 < 0) lat8 = k;
                if (bus5.done && lat5 < 0) lat5 = k;
            end
            check("rnd8_lat", lat8, 9);
            check("rnd8_res", {bus8.Sum, bus8.Cout, bus8.Overflow}, {8'(es8), ec8, eo8});
            check("rnd5_lat", lat5, 6);
            check("rnd5_res", {bus5.Sum, bus5.Cout, bus5.Overflow}, {5'(es5), ec5, eo5});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
